// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag-vector indices shared by alu_seq and its bench.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_O = 3;
    localparam int FLG_W = 4;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one partial product per cycle over WIDTH cycles.
// done flags the final step; prod already includes that step so the caller registers it on the same edge.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done = (cnt_q == CW'(1));

    always_comb begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and flags held in a one-entry output register.
// Define ALU_MUL_EN to build the multi-cycle MUL; without it op 110 completes at once with err set.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             o_flag,
    output logic             err
);
`ifdef ALU_MUL_EN
    localparam logic MUL_HW = 1'b1;
`else
    localparam logic MUL_HW = 1'b0;
`endif

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d, err_q, err_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res, ld_res;
    logic               alu_c, alu_o, ld, ld_c, ld_o, accept, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign z_flag    = flags_q[FLG_Z];
    assign n_flag    = flags_q[FLG_N];
    assign c_flag    = flags_q[FLG_C];
    assign o_flag    = flags_q[FLG_O];

`ifdef ALU_MUL_EN
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(accept && op == OP_MUL),
        .a    (a),
        .b    (b),
        .done (mul_done),
        .prod (mul_prod)
    );
`else
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_o   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_o   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOV: alu_res = a;
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        err_d       = err_q;
        ld          = accept && !(op == OP_MUL && MUL_HW);
        ld_res      = alu_res;
        ld_c        = alu_c;
        ld_o        = alu_o;
        if (accept && !ld) state_d = ST_MUL;
        if (state_q == ST_MUL && mul_done) begin
            state_d = ST_IDLE;
            ld      = 1'b1;
            ld_res  = mul_prod[WIDTH-1:0];
            ld_c    = |mul_prod[2*WIDTH-1:WIDTH];
            ld_o    = 1'b0;
        end
        if (ld) begin
            out_valid_d    = 1'b1;
            result_d       = ld_res;
            err_d          = !MUL_HW && state_q == ST_IDLE && op == OP_MUL;
            flags_d[FLG_Z] = (ld_res == '0);
            flags_d[FLG_N] = ld_res[WIDTH-1];
            flags_d[FLG_C] = ld_c;
            flags_d[FLG_O] = ld_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=8 against a behavioural arithmetic model.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, z_flag, n_flag, c_flag, o_flag, err;
    logic [7:0] result;
    int         tests = 0, fails = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .z_flag   (z_flag),
        .n_flag   (n_flag),
        .c_flag   (c_flag),
        .o_flag   (o_flag),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        logic       e;
        int         due;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
        logic       e;
        int         lat;
    } vec_t;

    // Flags packed as {z, n, c, o}.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t m;
        int ux, uy, sx, sy, full, s;
        logic c, ov;
        logic [7:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        full = 0;
        s = 0;
        c = 1'b0;
        ov = 1'b0;
        r = '0;
        m.e = 1'b0;
        m.due = 0;
        case (o)
            OP_ADD: begin
                full = ux + uy; r = full[7:0]; c = full > 255;
                s = sx + sy; ov = s > 127 || s < -128;
            end
            OP_SUB: begin
                full = ux - uy; r = full[7:0]; c = ux >= uy;
                s = sx - sy; ov = s > 127 || s < -128;
            end
            OP_MOV: r = x;
            OP_SHR: begin
                full = ux / 2; r = full[7:0]; c = (ux % 2) == 1;
            end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_SHL: begin
                full = ux * 2; r = full[7:0]; c = full > 255;
            end
            default: begin
                if (MUL_ON) begin
                    full = ux * uy; r = full[7:0]; c = full > 255;
                end else begin
                    m.e = 1'b1;
                end
            end
        endcase
        m.r = r;
        m.f = {r == 8'h00, r >= 8'h80, c, ov};
        return m;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h7F;
            3: return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // Issues one request with out_ready high and returns what the block presented, plus the
    // number of edges after the accepting edge before out_valid rose.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] r, output logic [3:0] f, output logic e,
                          output int lat, output bit ok);
        int n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = out_valid;
        r = result;
        f = {z_flag, n_flag, c_flag, o_flag};
        e = err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        tests++;
        if (result !== 8'h00) begin fails++; $display("FAIL reset result: got %h want 00", result); end
        tests++;
        if ({z_flag, n_flag, c_flag, o_flag} !== 4'b0000) begin
            fails++; $display("FAIL reset flags: got %b want 0000", {z_flag, n_flag, c_flag, o_flag});
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset err: got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready after release: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        vec_t v[$];
        logic [7:0] r;
        logic [3:0] f;
        logic e;
        int lat;
        bit ok;
        v.push_back('{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0, 0});
        v.push_back('{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1010, 1'b0, 0});
        v.push_back('{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0100, 1'b0, 0});
        v.push_back('{OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0, 0});
        v.push_back('{OP_SHR, 8'h01, 8'h00, 8'h00, 4'b1010, 1'b0, 0});
        v.push_back('{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0, 0});
        v.push_back('{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0, 0});
        v.push_back('{OP_MOV, 8'h5A, 8'hC3, 8'h5A, 4'b0000, 1'b0, 0});
        v.push_back('{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 0});
`ifdef ALU_MUL_EN
        v.push_back('{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1010, 1'b0, WIDTH});
        v.push_back('{OP_MUL, 8'h0F, 8'h03, 8'h2D, 4'b0000, 1'b0, WIDTH});
`else
        v.push_back('{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1000, 1'b1, 0});
`endif
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, r, f, e, lat, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL directed[%0d] out_valid: got 0 want 1 within 50 cycles", i); end
            tests++;
            if (r !== v[i].r) begin fails++; $display("FAIL directed[%0d] result: got %h want %h", i, r, v[i].r); end
            tests++;
            if (f !== v[i].f) begin fails++; $display("FAIL directed[%0d] flags znco: got %b want %b", i, f, v[i].f); end
            tests++;
            if (e !== v[i].e) begin fails++; $display("FAIL directed[%0d] err: got %b want %b", i, e, v[i].e); end
            tests++;
            if (lat != v[i].lat) begin fails++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xa[4], xb[4], want[4];
        int n = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = OP_OR;
        a = 8'hF0;
        b = 8'h0F;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        op = OP_ADD;
        a = 8'h01;
        b = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || result !== 8'hFF) begin
                fails++; $display("FAIL stall[%0d] held output: got v=%b r=%h want v=1 r=ff", i, out_valid, result);
            end
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL stall[%0d] in_ready: got %b want 0", i, in_ready); end
        end
        for (int i = 0; i < 4; i++) begin
            xa[i] = 8'($urandom);
            xb[i] = 8'($urandom);
            want[i] = xa[i] + xb[i];
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = xa[i];
            b = xb[i];
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== want[i]) begin
                fails++; $display("FAIL b2b[%0d]: got v=%b r=%h want v=1 r=%h", i, out_valid, result, want[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b drained out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t m;
        int edge_no = 0;
        logic ov_exp, ir_exp;
        for (int i = 0; i < 340; i++) begin
            @(negedge clk);
            in_valid  = (i < 300) && ($urandom_range(0, 9) < 7);
            out_ready = (i >= 300) || ($urandom_range(0, 3) != 0);
            op = 3'($urandom);
            a = pick();
            b = pick();
            #1;
            ov_exp = q.size() > 0 && edge_no >= q[0].due;
            ir_exp = q.size() == 0 || (ov_exp && out_ready);
            tests++;
            if (out_valid !== ov_exp) begin fails++; $display("FAIL random[%0d] out_valid: got %b want %b", i, out_valid, ov_exp); end
            tests++;
            if (in_ready !== ir_exp) begin fails++; $display("FAIL random[%0d] in_ready: got %b want %b", i, in_ready, ir_exp); end
            if (out_valid && out_ready && q.size() > 0) begin
                m = q.pop_front();
                tests++;
                if (result !== m.r || {z_flag, n_flag, c_flag, o_flag} !== m.f || err !== m.e) begin
                    fails++;
                    $display("FAIL random[%0d] output: got r=%h znco=%b e=%b want r=%h znco=%b e=%b",
                             i, result, {z_flag, n_flag, c_flag, o_flag}, err, m.r, m.f, m.e);
                end
            end
            if (in_valid && in_ready) begin
                m = model(op, a, b);
                m.due = edge_no + 1 + ((MUL_ON && op == OP_MUL) ? WIDTH : 0);
                q.push_back(m);
            end
            @(posedge clk);
            edge_no++;
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL random drain: got %0d results pending want 0", q.size()); end
    endtask

    task automatic test_mul_reset();
        logic [7:0] r;
        logic [3:0] f;
        logic e;
        int lat;
        bit ok, seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = OP_MUL;
        a = 8'h10;
        b = 8'h10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 8'h00 || {z_flag, n_flag, c_flag, o_flag} !== 4'b0000 || err !== 1'b0) begin
            fails++;
            $display("FAIL mul_reset outputs: got v=%b r=%h znco=%b e=%b want all 0",
                     out_valid, result, {z_flag, n_flag, c_flag, o_flag}, err);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL mul_reset in_ready after release: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL mul_reset abandoned op: got out_valid 1 want 0"); end
        run_op(OP_ADD, 8'h12, 8'h34, r, f, e, lat, ok);
        tests++;
        if (!ok || r !== 8'h46 || f !== 4'b0000 || lat != 0) begin
            fails++; $display("FAIL mul_reset follow-up ADD: got v=%b r=%h znco=%b lat=%0d want v=1 r=46 znco=0000 lat=0", ok, r, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mul_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
